calc_op_sequencer: RTL and testbench

Sequential front-end for the 4-bit calculator datapath. It accepts one command (opcode plus two operands) over a valid/ready handshake and issues it to the arithmetic stage. Add and subtract complete in one cycle; multiply runs as a shift-add over W cycles. The registered result is held on a valid/ready output until the consumer (display or register-file stage) takes it.

---
 rtl/calc_op_sequencer_if.sv | 27 ++
 rtl/calc_op_sequencer.sv | 128 ++++++++++++
 tb/tb_calc_op_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/calc_op_sequencer_if.sv
// Command/result handshake bundle for calc_op_sequencer.
// The slave modport is the sequencer side. The master modport is the producer/consumer side.
interface calc_op_sequencer_if #(
  parameter int W = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_op;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_result;
  logic           out_flag;
  logic           out_err;
  logic           busy;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_flag, out_err, busy
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_flag, out_err, busy
  );
endinterface

// File: rtl/calc_op_sequencer.sv
// Calculator front-end: add/sub finish in one cycle, and the result is held until the consumer takes it.
// Optional CALC_MUL_EN builds a W-cycle shift-add multiplier; without it, op 10 is reported as an error.
module calc_op_sequencer #(
  parameter int W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  calc_op_sequencer_if.slave bus
);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
`ifdef CALC_MUL_EN
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam int         CW     = $clog2(W);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_HOLD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd2} state_t;
`endif

  state_t         r_state, w_next;
  logic [2*W-1:0] r_result;
  logic           r_flag;
  logic           r_err;
  logic           w_accept;
  logic [W:0]     w_sum;
  logic [W-1:0]   w_diff;

  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_sum    = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  assign w_diff   = bus.in_a - bus.in_b;

`ifdef CALC_MUL_EN
  logic [W-1:0]   r_a, r_b;
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] w_partial, w_acc_nxt;
  logic           w_last;

  // Each MUL cycle adds one partial product, so the final sum goes straight into the result register.
  assign w_partial = {{W{1'b0}}, r_a} << r_cnt;
  assign w_acc_nxt = r_acc + (r_b[r_cnt] ? w_partial : '0);
  assign w_last    = (r_cnt == CW'(W - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef CALC_MUL_EN
          if (bus.in_op == OP_MUL) w_next = S_MUL;
          else                     w_next = S_HOLD;
`else
          w_next = S_HOLD;
`endif
        end
      end
`ifdef CALC_MUL_EN
      S_MUL:   if (w_last) w_next = S_HOLD;
`endif
      S_HOLD:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flag   <= 1'b0;
      r_err    <= 1'b0;
`ifdef CALC_MUL_EN
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
`endif
    end else if (w_accept) begin
      case (bus.in_op)
        OP_ADD: begin
          r_result <= {{(W-1){1'b0}}, w_sum};
          r_flag   <= w_sum[W];
          r_err    <= 1'b0;
        end
        OP_SUB: begin
          r_result <= {{W{1'b0}}, w_diff};
          r_flag   <= (bus.in_a < bus.in_b);
          r_err    <= 1'b0;
        end
`ifdef CALC_MUL_EN
        OP_MUL: begin
          r_a   <= bus.in_a;
          r_b   <= bus.in_b;
          r_acc <= '0;
          r_cnt <= '0;
          r_err <= 1'b0;
        end
`endif
        default: begin
          r_result <= '0;
          r_flag   <= 1'b0;
          r_err    <= 1'b1;
        end
      endcase
`ifdef CALC_MUL_EN
    end else if (r_state == S_MUL) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_result <= w_acc_nxt;
        r_flag   <= 1'b0;
      end
`endif
    end
  end

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.out_valid  = (r_state == S_HOLD);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.out_result = r_result;
  assign bus.out_flag   = r_flag;
  assign bus.out_err    = r_err;
endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer with directed cases, randomized traffic and reset aborts.
module tb_calc_op_sequencer;
  localparam int W = 4;

  typedef struct {
    logic [2*W-1:0] res;
    logic           flag;
    logic           err;
    int             acc;
    int             delta;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tot = 0;
  int   bad = 0;
  int   rdy_mode = 2;   // 0 random, 1 hold low, 2 hold high
  exp_t q[$];
  exp_t cur;
  bit   have_cur = 0;
  bit   exp_idle = 0;

  calc_op_sequencer_if #(.W(W)) bus();
  calc_op_sequencer #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tot++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model from the arithmetic rules, independent of the sequencer structure.
  function automatic exp_t model(input logic [1:0] op, input int a, input int b);
    exp_t e;
    e.res = '0; e.flag = 0; e.err = 0; e.acc = 0; e.delta = 0;
    case (op)
      2'b00: begin e.res = (2*W)'(a + b); e.flag = ((a + b) >= (1 << W)); end
      2'b01: begin e.res = (2*W)'((a - b + (1 << W)) % (1 << W)); e.flag = (a < b); end
`ifdef CALC_MUL_EN
      2'b10: begin e.res = (2*W)'(a * b); e.delta = W; end
`endif
      default: e.err = 1;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input int a, input int b);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = W'(a); bus.in_b = W'(b);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    e = model(op, a, b);
    e.acc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || have_cur || !bus.in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 0) bus.out_ready = 1'($urandom_range(0, 1));
      else               bus.out_ready = (rdy_mode == 2);
    end
  end

  // Monitor: pops on first out_valid cycle, checks latency, stability and state-derived flags.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_cur = 0;
        exp_idle = 0;
      end else if (bus.out_valid) begin
        if (!have_cur) begin
          if (q.size() == 0) begin
            chk("spurious_out_valid", 1, 0);
            continue;
          end
          cur = q.pop_front();
          have_cur = 1;
          chk("latency", cyc - cur.acc, cur.delta);
        end
        chk("result", bus.out_result, cur.res);
        chk("flag", bus.out_flag, cur.flag);
        chk("err", bus.out_err, cur.err);
        chk("in_ready_hold", bus.in_ready, 0);
        chk("busy_hold", bus.busy, 1);
        if (bus.out_ready) begin
          have_cur = 0;
          exp_idle = 1;
        end
      end else begin
        if (exp_idle) begin
          chk("in_ready_after_hs", bus.in_ready, 1);
          exp_idle = 0;
        end
        if (q.size() > 0 && cyc >= q[0].acc) begin
          chk("busy_inflight", bus.busy, 1);
          chk("in_ready_inflight", bus.in_ready, 0);
        end else begin
          chk("busy_idle", bus.busy, 0);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_a = '0; bus.in_b = '0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_result", bus.out_result, 0);
    chk("rst_err", bus.out_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue(2'b00, 9, 8);
    issue(2'b01, 3, 5);
    issue(2'b01, 7, 2);
    issue(2'b10, 15, 15);
    issue(2'b10, 0, 9);
    issue(2'b11, 6, 6);
    issue(2'b00, 15, 15);
    issue(2'b10, 2, 3);
    issue(2'b00, 0, 0);
    wait_idle();

    // Back-pressure: result must hold and a competing command must be ignored.
    rdy_mode = 1;
    issue(2'b00, 1, 1);
    repeat (10) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_op = 2'b01; bus.in_a = 4'd5; bus.in_b = 4'd1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rdy_mode = 2;
    wait_idle();

`ifdef CALC_MUL_EN
    // Reset during the second MUL cycle aborts the multiply.
    issue(2'b10, 13, 11);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_mul_valid", bus.out_valid, 0);
    chk("abort_mul_busy", bus.busy, 0);
    chk("abort_mul_ready", bus.in_ready, 1);
    chk("abort_mul_result", bus.out_result, 0);
    q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);
    chk("abort_mul_no_stale", bus.out_valid, 0);
`endif

    // Reset while holding a result discards it.
    rdy_mode = 1;
    issue(2'b11, 1, 2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_hold_valid", bus.out_valid, 0);
    chk("abort_hold_err", bus.out_err, 0);
    chk("abort_hold_ready", bus.in_ready, 1);
    q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 2;
    @(negedge clk);
    chk("abort_hold_no_stale", bus.out_valid, 0);

    rdy_mode = 0;
    for (int i = 0; i < 150; i++) begin
      issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    rdy_mode = 2;
    wait_idle();

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
